// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, checker indices, verdict causes and dispatcher states.
// Imported by board_validator, game_play and the move dispatcher.
package chess_pkg;

  localparam logic [3:0] WKing   = 4'd0;
  localparam logic [3:0] WQueen  = 4'd1;
  localparam logic [3:0] WBishop = 4'd2;
  localparam logic [3:0] WKnight = 4'd3;
  localparam logic [3:0] WRook   = 4'd4;
  localparam logic [3:0] WPawn   = 4'd5;
  localparam logic [3:0] BKing   = 4'd6;
  localparam logic [3:0] BQueen  = 4'd7;
  localparam logic [3:0] BBishop = 4'd8;
  localparam logic [3:0] BKnight = 4'd9;
  localparam logic [3:0] BRook   = 4'd10;
  localparam logic [3:0] BPawn   = 4'd11;
  localparam logic [3:0] Empty   = 4'd15;

  typedef enum logic [2:0] {
    IdxKing   = 3'd0,
    IdxQueen  = 3'd1,
    IdxBishop = 3'd2,
    IdxKnight = 3'd3,
    IdxRook   = 3'd4,
    IdxPawn   = 3'd5
  } piece_idx_e;

  typedef enum logic [2:0] {
    RejNone       = 3'd0,
    RejNullMove   = 3'd1,
    RejEmptySrc   = 3'd2,
    RejBadCode    = 3'd3,
    RejWrongSide  = 3'd4,
    RejOwnCapture = 3'd5,
    RejGeometry   = 3'd6,
    RejTimeout    = 3'd7
  } reject_e;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StPrecheck,
    StStart,
    StWait,
    StResult
  } disp_state_e;

  function automatic logic is_black(input logic [3:0] code);
    return (code >= BKing) && (code <= BPawn);
  endfunction

  // Only meaningful for codes 0..11; anything else maps to the king slot.
  function automatic piece_idx_e piece_idx(input logic [3:0] code);
    logic [3:0] m;
    m = (code >= BKing) ? (code - BKing) : code;
    return (code <= BPawn) ? piece_idx_e'(m[2:0]) : IdxKing;
  endfunction

endpackage

// File: rtl/move_dispatcher_if.sv
// Request/verdict and checker handshake bundle of the move dispatcher.
// master = game_play plus the per-piece checkers, slave = dispatcher.
interface move_dispatcher_if;

  logic       req_valid;
  logic [2:0] old_x;
  logic [2:0] old_y;
  logic [2:0] new_x;
  logic [2:0] new_y;
  logic       turn_black;
  logic [3:0] board_in [8][8];
  logic       req_ready;
  logic [2:0] h_delta;
  logic [2:0] v_delta;
  logic [3:0] piece_type;
  logic [5:0] chk_rst_n;
  logic [5:0] chk_done;
  logic [5:0] chk_valid;
  logic       done;
  logic       move_valid;
  logic [2:0] reject_code;

  modport master (
    output req_valid, old_x, old_y, new_x, new_y, turn_black, board_in, chk_done, chk_valid,
    input  req_ready, h_delta, v_delta, piece_type, chk_rst_n, done, move_valid, reject_code
  );

  modport slave (
    input  req_valid, old_x, old_y, new_x, new_y, turn_black, board_in, chk_done, chk_valid,
    output req_ready, h_delta, v_delta, piece_type, chk_rst_n, done, move_valid, reject_code
  );

endinterface

// File: rtl/move_decode.sv
// Combinational move decode: unsigned square deltas plus colour/class of source and destination.
module move_decode
  import chess_pkg::*;
(
  input  logic [2:0]  old_x_i,
  input  logic [2:0]  old_y_i,
  input  logic [2:0]  new_x_i,
  input  logic [2:0]  new_y_i,
  input  logic [3:0]  src_code_i,
  input  logic [3:0]  dst_code_i,
  output logic [2:0]  h_delta_o,
  output logic [2:0]  v_delta_o,
  output logic        src_black_o,
  output logic        dst_black_o,
  output logic        src_empty_o,
  output logic        src_bad_o,
  output logic        dst_piece_o,
  output piece_idx_e  src_idx_o
);

  function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    logic signed [3:0] d;
    logic signed [3:0] n;
    d = $signed({1'b0, b}) - $signed({1'b0, a});
    n = -d;
    return d[3] ? n[2:0] : d[2:0];
  endfunction

  always_comb begin
    h_delta_o   = abs_diff(old_x_i, new_x_i);
    v_delta_o   = abs_diff(old_y_i, new_y_i);
    src_black_o = is_black(src_code_i);
    dst_black_o = is_black(dst_code_i);
    src_empty_o = (src_code_i == Empty);
    src_bad_o   = (src_code_i > BPawn) && (src_code_i != Empty);
    dst_piece_o = (dst_code_i <= BPawn);
    src_idx_o   = piece_idx(src_code_i);
  end

endmodule

// File: rtl/move_dispatcher.sv
// Move dispatcher: decodes one move request, runs the side/occupancy prechecks, restarts the
// matching per-piece checker and returns one registered verdict per request.
module move_dispatcher
  import chess_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic             clk,
  input  logic             reset,
  move_dispatcher_if.slave bus
);

  localparam int unsigned      TimerW    = $clog2(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);

  disp_state_e state_q, state_d;

  logic [2:0]        old_x_q, old_y_q, new_x_q, new_y_q;
  logic              turn_q;
  logic [3:0]        piece_type_q, dst_code_q;
  logic [2:0]        h_q, v_q;
  logic [TimerW-1:0] timer_q;
  logic              move_valid_q, move_valid_d;
  reject_e           reject_q, reject_d, pre_reject;
  logic              verdict_load;

  logic [3:0] src_code, dst_code;
  logic [2:0] h_dec, v_dec;
  logic       src_black, dst_black, src_empty, src_bad, dst_piece;
  piece_idx_e src_idx;
  logic       sel_done, sel_valid;

  logic       req_ready, done;
  logic [5:0] chk_rst_n;

  assign src_code = bus.board_in[old_y_q][old_x_q];
  assign dst_code = bus.board_in[new_y_q][new_x_q];

  // Deltas come from the latched squares; colour/index from the codes registered in DECODE.
  move_decode u_decode (
    .old_x_i     (old_x_q),
    .old_y_i     (old_y_q),
    .new_x_i     (new_x_q),
    .new_y_i     (new_y_q),
    .src_code_i  (piece_type_q),
    .dst_code_i  (dst_code_q),
    .h_delta_o   (h_dec),
    .v_delta_o   (v_dec),
    .src_black_o (src_black),
    .dst_black_o (dst_black),
    .src_empty_o (src_empty),
    .src_bad_o   (src_bad),
    .dst_piece_o (dst_piece),
    .src_idx_o   (src_idx)
  );

  assign sel_done  = bus.chk_done[src_idx];
  assign sel_valid = bus.chk_valid[src_idx];

  always_comb begin
    pre_reject = RejNone;
    if (h_q == 3'd0 && v_q == 3'd0) begin
      pre_reject = RejNullMove;
    end else if (src_empty) begin
      pre_reject = RejEmptySrc;
    end else if (src_bad) begin
      pre_reject = RejBadCode;
    end else if (src_black != turn_q) begin
      pre_reject = RejWrongSide;
    end else if (dst_piece && (dst_black == src_black)) begin
      pre_reject = RejOwnCapture;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    verdict_load = 1'b0;
    move_valid_d = 1'b0;
    reject_d     = RejNone;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) state_d = StDecode;
      end
      StDecode: state_d = StPrecheck;
      StPrecheck: begin
        if (pre_reject != RejNone) begin
          verdict_load = 1'b1;
          reject_d     = pre_reject;
          state_d      = StResult;
        end else begin
          state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        // timer_q == 0 marks the first WAIT cycle, where a done can only be stale.
        if ((timer_q != '0) && sel_done) begin
          verdict_load = 1'b1;
          move_valid_d = sel_valid;
          reject_d     = sel_valid ? RejNone : RejGeometry;
          state_d      = StResult;
        end else if (timer_q == TimerLast) begin
          verdict_load = 1'b1;
          reject_d     = RejTimeout;
          state_d      = StResult;
        end
      end
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    done      = (state_q == StResult);
    chk_rst_n = 6'h3F;
    if (state_q == StStart) chk_rst_n[src_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      old_x_q      <= '0;
      old_y_q      <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      turn_q       <= 1'b0;
      piece_type_q <= '0;
      dst_code_q   <= '0;
      h_q          <= '0;
      v_q          <= '0;
      timer_q      <= '0;
      move_valid_q <= 1'b0;
      reject_q     <= RejNone;
    end else begin
      if (state_q == StIdle && bus.req_valid) begin
        old_x_q <= bus.old_x;
        old_y_q <= bus.old_y;
        new_x_q <= bus.new_x;
        new_y_q <= bus.new_y;
        turn_q  <= bus.turn_black;
      end
      if (state_q == StDecode) begin
        piece_type_q <= src_code;
        dst_code_q   <= dst_code;
        h_q          <= h_dec;
        v_q          <= v_dec;
      end
      if (state_q == StStart) begin
        timer_q <= '0;
      end else if (state_q == StWait) begin
        timer_q <= timer_q + 1'b1;
      end
      if (verdict_load) begin
        move_valid_q <= move_valid_d;
        reject_q     <= reject_d;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.done        = done;
  assign bus.chk_rst_n   = chk_rst_n;
  assign bus.h_delta     = h_q;
  assign bus.v_delta     = v_q;
  assign bus.piece_type  = piece_type_q;
  assign bus.move_valid  = move_valid_q;
  assign bus.reject_code = reject_q;

endmodule

// File: tb/tb_move_dispatcher.sv
// Directed bench for move_dispatcher with behavioural checker stubs and a simple pawn rule.
module tb_move_dispatcher;
  import chess_pkg::*;

  localparam int unsigned TO   = 32;
  localparam int          NCYC = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_dispatcher_if bus ();

  move_dispatcher #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Checker stubs: restarted by chk_rst_n, answer on the 2nd cycle after restart if enabled.
  logic [5:0] stub_en, stub_valid, force_done, busy_q;
  logic [1:0] cnt_q [6];
  logic       pawn_ok;

  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (reset) begin
        busy_q[i] <= 1'b0;
        cnt_q[i]  <= 2'd0;
      end else if (!bus.chk_rst_n[i]) begin
        busy_q[i] <= 1'b1;
        cnt_q[i]  <= 2'd0;
      end else if (busy_q[i] && cnt_q[i] != 2'd3) begin
        cnt_q[i] <= cnt_q[i] + 2'd1;
      end
    end
  end

  always_comb begin
    pawn_ok      = (bus.h_delta == 3'd0) && (bus.v_delta == 3'd1 || bus.v_delta == 3'd2);
    bus.chk_done = force_done;
    for (int i = 0; i < 6; i++) begin
      if (busy_q[i] && cnt_q[i] == 2'd1 && stub_en[i]) bus.chk_done[i] = 1'b1;
    end
    bus.chk_valid    = stub_valid;
    bus.chk_valid[5] = pawn_ok;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current cycle (cycle 0) and observes NCYC following cycles.
  task automatic run_req(input logic [2:0] ox, input logic [2:0] oy, input logic [2:0] nx,
                         input logic [2:0] ny, input logic tb, input int pulse_at,
                         output int done_cyc, output int n_done, output logic mv,
                         output logic [2:0] rc, output logic [2:0] h, output logic [2:0] v,
                         output logic [3:0] pt, output logic [5:0] crn3, output logic crn_low,
                         output logic rdy1, output logic mv_end);
    done_cyc = -1;
    n_done   = 0;
    mv = 1'bx; rc = 'x; h = 'x; v = 'x; pt = 'x;
    crn3 = '1; crn_low = 1'b0; rdy1 = 1'bx;
    bus.old_x = ox; bus.old_y = oy; bus.new_x = nx; bus.new_y = ny;
    bus.turn_black = tb;
    bus.req_valid  = 1'b1;
    for (int c = 1; c <= NCYC; c++) begin
      step();
      bus.req_valid = (c == pulse_at);
      if (c == 1) rdy1 = bus.req_ready;
      if (c == 3) crn3 = bus.chk_rst_n;
      if (bus.chk_rst_n != 6'h3F) crn_low = 1'b1;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          mv = bus.move_valid; rc = bus.reject_code;
          h = bus.h_delta; v = bus.v_delta; pt = bus.piece_type;
        end
      end
    end
    mv_end = bus.move_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd;
    logic mv, crn_low, rdy1, mv_end;
    logic [2:0] rc, h, v;
    logic [3:0] pt;
    logic [5:0] crn3;
    logic [3:0] back_w [8];
    logic [3:0] back_b [8];

    back_w = '{WRook, WKnight, WBishop, WQueen, WKing, WBishop, WKnight, WRook};
    back_b = '{BRook, BKnight, BBishop, BQueen, BKing, BBishop, BKnight, BRook};
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        bus.board_in[y][x] = (y == 0) ? back_b[x] : (y == 1) ? BPawn :
                             (y == 6) ? WPawn : (y == 7) ? back_w[x] : Empty;
      end
    end
    stub_en    = 6'b110111;
    stub_valid = 6'b000000;
    force_done = 6'b000000;
    bus.req_valid = 1'b0;
    bus.old_x = 0; bus.old_y = 0; bus.new_x = 0; bus.new_y = 0; bus.turn_black = 1'b0;

    reset = 1'b1;
    repeat (3) step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_chk_rst_n", 32'(bus.chk_rst_n), 32'h3F);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_move_valid", 32'(bus.move_valid), 32'd0);
    check("rst_reject", 32'(bus.reject_code), 32'd0);
    check("rst_deltas_type", {21'd0, bus.h_delta, bus.v_delta, bus.piece_type}, 32'd0);
    reset = 1'b0;
    step();

    // White pawn e2->e4 through the real pawn rule.
    run_req(3'd4, 3'd6, 3'd4, 3'd4, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("e2e4_ready_c1", 32'(rdy1), 32'd0);
    check("e2e4_chk_rst_n_c3", 32'(crn3), 32'h1F);
    check("e2e4_done_cyc", 32'(dc), 32'd6);
    check("e2e4_n_done", 32'(nd), 32'd1);
    check("e2e4_valid", 32'(mv), 32'd1);
    check("e2e4_reject", 32'(rc), 32'd0);
    check("e2e4_h", 32'(h), 32'd0);
    check("e2e4_v", 32'(v), 32'd2);
    check("e2e4_type", 32'(pt), 32'd5);
    check("e2e4_valid_held", 32'(mv_end), 32'd1);

    // Empty source square.
    run_req(3'd4, 3'd4, 3'd4, 3'd3, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("empty_done_cyc", 32'(dc), 32'd3);
    check("empty_valid", 32'(mv), 32'd0);
    check("empty_reject", 32'(rc), 32'd2);
    check("empty_no_restart", 32'(crn_low), 32'd0);

    // Black pawn a7 moved on white's turn.
    run_req(3'd0, 3'd1, 3'd0, 3'd2, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("wrong_side_reject", 32'(rc), 32'd4);
    check("wrong_side_done_cyc", 32'(dc), 32'd3);

    // White rook a1 onto own pawn a2.
    run_req(3'd0, 3'd7, 3'd0, 3'd6, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("own_capture_reject", 32'(rc), 32'd5);

    // Knight b1->c3 with a silent knight stub and a stray king done held high.
    force_done = 6'b000001;
    run_req(3'd1, 3'd7, 3'd2, 3'd5, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    force_done = 6'b000000;
    check("timeout_done_cyc", 32'(dc), 32'd36);
    check("timeout_n_done", 32'(nd), 32'd1);
    check("timeout_valid", 32'(mv), 32'd0);
    check("timeout_reject", 32'(rc), 32'd7);
    check("knight_deltas", {26'd0, h, v}, {26'd0, 3'd1, 3'd2});
    check("knight_chk_rst_n_c3", 32'(crn3), 32'h37);

    // Null move straight after the timeout.
    run_req(3'd3, 3'd3, 3'd3, 3'd3, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("null_reject", 32'(rc), 32'd1);
    check("null_done_cyc", 32'(dc), 32'd3);

    // Queen d1->d3 with a stub that answers invalid.
    run_req(3'd3, 3'd7, 3'd3, 3'd5, 1'b0, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("geom_done_cyc", 32'(dc), 32'd6);
    check("geom_valid", 32'(mv), 32'd0);
    check("geom_reject", 32'(rc), 32'd6);
    check("geom_type", 32'(pt), 32'd1);

    // Second request pulsed during WAIT must be dropped.
    run_req(3'd4, 3'd6, 3'd4, 3'd4, 1'b0, 4, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("wait_pulse_n_done", 32'(nd), 32'd1);
    check("wait_pulse_done_cyc", 32'(dc), 32'd6);

    // Black pawn e7->e5 on black's turn (positive row direction).
    run_req(3'd4, 3'd1, 3'd4, 3'd3, 1'b1, -1, dc, nd, mv, rc, h, v, pt, crn3, crn_low, rdy1,
            mv_end);
    check("e7e5_valid", 32'(mv), 32'd1);
    check("e7e5_v", 32'(v), 32'd2);
    check("e7e5_type", 32'(pt), 32'd11);

    // Reset asserted in the first WAIT cycle.
    bus.old_x = 3'd4; bus.old_y = 3'd6; bus.new_x = 3'd4; bus.new_y = 3'd4;
    bus.turn_black = 1'b0;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_chk_rst_n", 32'(bus.chk_rst_n), 32'h3F);
    check("mid_rst_valid", 32'(bus.move_valid), 32'd0);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) nd++;
      step();
    end
    check("mid_rst_no_done", 32'(nd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
